// File: rtl/hv_rac_req_sched.sv
// Round-robin scheduler sharing the single rac port between SPI, OWT and loader.
// One transaction is locked until the rac acks or the timeout expires, then a one-cycle ack returns to the owner.
module hv_rac_req_sched #(
  parameter int REG_AW    = 7,
  parameter int REG_DW    = 8,
  parameter int REG_CRC_W = 8,
  parameter int TO_CYC    = 255,
  parameter int TO_W      = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_spi_req,
  input  logic                 i_owt_req,
  input  logic                 i_ldr_req,
  input  logic                 i_spi_we,
  input  logic                 i_owt_we,
  input  logic                 i_ldr_we,
  input  logic [REG_AW-1:0]    i_spi_addr,
  input  logic [REG_AW-1:0]    i_owt_addr,
  input  logic [REG_AW-1:0]    i_ldr_addr,
  input  logic [REG_DW-1:0]    i_spi_wdata,
  input  logic [REG_DW-1:0]    i_owt_wdata,
  input  logic [REG_DW-1:0]    i_ldr_wdata,
  input  logic [REG_CRC_W-1:0] i_spi_wcrc,
  input  logic [REG_CRC_W-1:0] i_owt_wcrc,
  input  logic [REG_CRC_W-1:0] i_ldr_wcrc,
  output logic                 o_spi_ack,
  output logic                 o_owt_ack,
  output logic                 o_ldr_ack,
  output logic                 o_spi_err,
  output logic                 o_owt_err,
  output logic                 o_ldr_err,
  output logic [REG_DW-1:0]    o_rdata,
  output logic                 o_rac_wr_req,
  output logic                 o_rac_rd_req,
  output logic [REG_AW-1:0]    o_rac_addr,
  output logic [REG_DW-1:0]    o_rac_wdata,
  output logic [REG_CRC_W-1:0] o_rac_wcrc,
  input  logic                 i_rac_wack,
  input  logic                 i_rac_rack,
  input  logic [REG_DW-1:0]    i_rac_data,
  output logic                 o_busy,
  output logic [1:0]           o_gnt_id
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [TO_W-1:0] LP_TO  = TO_W'(TO_CYC);
  localparam logic [TO_W-1:0] LP_ONE = TO_W'(1);

  state_t                 r_state;
  logic [1:0]             r_last;
  logic [1:0]             r_gnt;
  logic [TO_W-1:0]        r_cnt;
  logic                   r_we;
  logic                   r_wr_req;
  logic                   r_rd_req;
  logic [REG_AW-1:0]      r_addr;
  logic [REG_DW-1:0]      r_wdata;
  logic [REG_CRC_W-1:0]   r_wcrc;
  logic [2:0]             r_ack;
  logic [2:0]             r_err;
  logic [REG_DW-1:0]      r_rdata;

  logic [1:0]             w_pick;
  logic                   w_we;
  logic [REG_AW-1:0]      w_addr;
  logic [REG_DW-1:0]      w_wdata;
  logic [REG_CRC_W-1:0]   w_wcrc;
  logic                   w_done_ack;
  logic                   w_tmo;
  logic [TO_W-1:0]        w_cnt_nxt;
  logic [2:0]             w_oh;

  // Search starts at the source following the last one served
  always_comb begin
    w_pick = 2'd0;
    case (r_last)
      2'd1: begin
        if (i_owt_req)      w_pick = 2'd2;
        else if (i_ldr_req) w_pick = 2'd3;
        else if (i_spi_req) w_pick = 2'd1;
      end
      2'd2: begin
        if (i_ldr_req)      w_pick = 2'd3;
        else if (i_spi_req) w_pick = 2'd1;
        else if (i_owt_req) w_pick = 2'd2;
      end
      default: begin
        if (i_spi_req)      w_pick = 2'd1;
        else if (i_owt_req) w_pick = 2'd2;
        else if (i_ldr_req) w_pick = 2'd3;
      end
    endcase
  end

  always_comb begin
    w_we    = i_spi_we;
    w_addr  = i_spi_addr;
    w_wdata = i_spi_wdata;
    w_wcrc  = i_spi_wcrc;
    case (w_pick)
      2'd2: begin
        w_we = i_owt_we; w_addr = i_owt_addr; w_wdata = i_owt_wdata; w_wcrc = i_owt_wcrc;
      end
      2'd3: begin
        w_we = i_ldr_we; w_addr = i_ldr_addr; w_wdata = i_ldr_wdata; w_wcrc = i_ldr_wcrc;
      end
      default: ;
    endcase
  end

  assign w_done_ack = r_we ? i_rac_wack : i_rac_rack;
  assign w_cnt_nxt  = r_cnt + LP_ONE;
  assign w_tmo      = (w_cnt_nxt == LP_TO);
  assign w_oh       = {r_gnt == 2'd3, r_gnt == 2'd2, r_gnt == 2'd1};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_last   <= 2'd3;
      r_gnt    <= 2'd0;
      r_cnt    <= '0;
      r_we     <= 1'b0;
      r_wr_req <= 1'b0;
      r_rd_req <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wcrc   <= '0;
      r_ack    <= '0;
      r_err    <= '0;
      r_rdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick != 2'd0) begin
            r_gnt    <= w_pick;
            r_we     <= w_we;
            r_addr   <= w_addr;
            r_wdata  <= w_wdata;
            r_wcrc   <= w_wcrc;
            r_wr_req <= w_we;
            r_rd_req <= ~w_we;
            r_cnt    <= '0;
            r_state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_cnt <= w_cnt_nxt;
          // A real ack on the timeout cycle still completes the access cleanly
          if (w_done_ack || w_tmo) begin
            r_wr_req <= 1'b0;
            r_rd_req <= 1'b0;
            r_ack    <= w_oh;
            r_err    <= w_done_ack ? 3'b000 : w_oh;
            r_rdata  <= (w_done_ack && !r_we) ? i_rac_data : '0;
            r_state  <= S_DONE;
          end
        end
        default: begin
          r_last  <= r_gnt;
          r_gnt   <= 2'd0;
          r_cnt   <= '0;
          r_ack   <= '0;
          r_err   <= '0;
          r_rdata <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_spi_ack    = r_ack[0];
  assign o_owt_ack    = r_ack[1];
  assign o_ldr_ack    = r_ack[2];
  assign o_spi_err    = r_err[0];
  assign o_owt_err    = r_err[1];
  assign o_ldr_err    = r_err[2];
  assign o_rdata      = r_rdata;
  assign o_rac_wr_req = r_wr_req;
  assign o_rac_rd_req = r_rd_req;
  assign o_rac_addr   = r_addr;
  assign o_rac_wdata  = r_wdata;
  assign o_rac_wcrc   = r_wcrc;
  assign o_busy       = (r_state != S_IDLE);
  assign o_gnt_id     = r_gnt;

endmodule

// File: doc/hv_rac_req_sched.md
Name: hv_rac_req_sched

Overview:
Round-robin scheduler for the single register-access-controller (rac) port, shared by three requesters: SPI slave, OWT/D2D receive path and the internal trim/config loader (ldr).
It locks one granted transaction until the rac acknowledges it or a timeout expires, then returns a one-cycle ack pulse, read data and error status to the owner.
It sits between the requesters and the rac block in hv_top and replaces fixed-priority muxing with fair, registered sequencing.

Parameters:
REG_AW, 7, register address width
REG_DW, 8, register data width
REG_CRC_W, 8, write CRC width
TO_CYC, 255, BUSY cycles without ack before timeout (1..2^TO_W-1)
TO_W, 8, timeout counter width

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous, active-high reset
i_spi_req / i_owt_req / i_ldr_req  in  1 each  request; level, held until own ack pulse
i_spi_we / i_owt_we / i_ldr_we  in  1 each  1 = write, 0 = read
i_spi_addr / i_owt_addr / i_ldr_addr  in  REG_AW each  address
i_spi_wdata / i_owt_wdata / i_ldr_wdata  in  REG_DW each  write data
i_spi_wcrc / i_owt_wcrc / i_ldr_wcrc  in  REG_CRC_W each  write CRC
o_spi_ack / o_owt_ack / o_ldr_ack  out  1 each  one-cycle completion pulse
o_spi_err / o_owt_err / o_ldr_err  out  1 each  timeout flag, valid with ack
o_rdata  out  REG_DW  read data, valid with any ack (shared)
o_rac_wr_req  out  1  write request to rac
o_rac_rd_req  out  1  read request to rac
o_rac_addr  out  REG_AW  latched address
o_rac_wdata  out  REG_DW  latched write data
o_rac_wcrc  out  REG_CRC_W  latched CRC
i_rac_wack  in  1  write ack
i_rac_rack  in  1  read ack
i_rac_data  in  REG_DW  read data
o_busy  out  1  FSM not IDLE
o_gnt_id  out  2  owner: 0 = none, 1 = spi, 2 = owt, 3 = ldr

Behaviour:
- Reset: every output 0, FSM = IDLE, timeout counter 0, last-served pointer = ldr, giving first-round priority spi > owt > ldr.
- Reset asserted mid-transaction aborts it: no ack is issued, and rac requests drop asynchronously.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - With any request present, pick the first requesting source after the last-served one in the cyclic order spi→owt→ldr.
  - Latch its we/addr/wdata/wcrc, set o_gnt_id, go to BUSY.
  - All request outputs are registered, so o_rac_wr_req = we or o_rac_rd_req = ~we asserts the cycle after the request is seen.
- BUSY:
  - rac request and latched fields are held stable. Requester input changes are ignored.
  - Counter increments each cycle.
  - Completion ack is i_rac_wack for a write and i_rac_rack for a read; the ack of the wrong type is ignored.
  - On completion ack: capture i_rac_data (reads only; o_rdata is 0 for writes), drop the rac request, and go to DONE with err = 0.
  - If the counter reaches TO_CYC without ack: drop the rac request, go to DONE with err = 1 and o_rdata = 0.
  - Ack in the same cycle as the counter reaches TO_CYC: ack wins, err = 0.
- DONE (exactly 1 cycle):
  - Owner's o_*_ack = 1; o_*_err and o_rdata are valid.
  - Last-served pointer = owner; counter cleared; next state IDLE.
- Requester rule: drop req in the cycle after the ack pulse.
  - The earliest new grant is therefore in the IDLE cycle following DONE.
- Minimum transaction: req seen (IDLE, t) → rac req at t+1 → ack at t+1 → ack pulse at t+2 → IDLE at t+3.
- o_busy = state != IDLE; o_gnt_id is nonzero in BUSY and DONE.
- A request deasserted while not granted is simply dropped; no state is kept.

Test Plan:
- Single SPI write, addr 0x12, data 0xA5: rac wack 2 cycles after o_rac_wr_req → o_rac_addr = 0x12, wdata = 0xA5 held stable; o_spi_ack pulses once, err = 0.
- OWT read, addr 0x05, rack with i_rac_data = 0x3C → o_rac_rd_req only; o_owt_ack pulses with o_rdata = 0x3C.
- All three request from reset and hold → grant order spi, owt, ldr, spi; one ack each in round-robin order; no back-to-back grant to the same source while others wait.
- TO_CYC = 4, no ack → rac req drops after 4 BUSY cycles; o_ldr_ack = 1, o_ldr_err = 1, o_rdata = 0; a later rac wack is ignored.
- Read granted and wack arrives → ignored; rack later completes the read normally. Ack on the timeout cycle → err = 0.
- Assert i_rst during BUSY → all outputs 0 immediately, no ack; after release the SPI request is granted first.
